// File: rtl/hr_dpwm_pkg.sv
// hr_dpwm_pkg: shared FSM states and sizing constants for the DPWM capture block
package hr_dpwm_pkg;
   typedef enum logic [2:0] {IDLE, ALIGN, H_ON, DT_HL, L_ON, DT_LH} cap_state_e;
   localparam int DC_LENGTH_DEF = 13;
   localparam int DE_BITS_DEF = 6;
   localparam logic [DC_LENGTH_DEF-1:0] CNT_SAT_DEF = '1;
endpackage

// File: rtl/dpwm_edge_sync.sv
// dpwm_edge_sync: multi-flop synchronizer for an asynchronous gate signal with rise/fall detect
module dpwm_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_base,
   input  logic rst,
   input  logic d_i,
   output logic s_o,
   output logic rise_o,
   output logic fall_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic prev_q;
   // shift the raw input through the synchronizer and keep the previous clean sample
   always_ff @(posedge clk_base) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end
   assign s_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = s_o & ~prev_q;
   assign fall_o = ~s_o & prev_q;
endmodule

// File: rtl/dpwm_capture.sv
// dpwm_capture: measures H on-time, H->L dead time, L on-time and L->H dead time per period
module dpwm_capture
   import hr_dpwm_pkg::*;
#(
   parameter int Dc_length   = DC_LENGTH_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk_base,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 H_DPWM,
   input  logic                 L_DPWM,
   output logic [Dc_length-1:0] H_on_meas,
   output logic [Dc_length-1:0] DT_HL_meas,
   output logic [Dc_length-1:0] L_on_meas,
   output logic [Dc_length-1:0] DT_LH_meas,
   output logic                 meas_valid,
   output logic                 overlap_err,
   output logic                 seq_err
);
   localparam logic [Dc_length-1:0] ONE      = Dc_length'(1);
   localparam logic [Dc_length-1:0] CNT_SAT  = '1;
   localparam logic [Dc_length-1:0] CNT_LAST = CNT_SAT - ONE;

   logic hs, h_rise, h_fall, ls, l_rise, l_fall;
   cap_state_e state_q, state_d;
   logic [Dc_length-1:0] cnt_q, cnt_d, h_q, h_d, dthl_q, dthl_d, l_q, l_d;
   logic [Dc_length-1:0] hon_q, hon_d, dthlm_q, dthlm_d, lon_q, lon_d, dtlh_q, dtlh_d;
   logic mv_q, mv_d, ovl_q, ovl_d, seq_q, seq_d, both_q, count;

   dpwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_h (
      .clk_base(clk_base), .rst(rst), .d_i(H_DPWM), .s_o(hs), .rise_o(h_rise), .fall_o(h_fall)
   );
   dpwm_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_l (
      .clk_base(clk_base), .rst(rst), .d_i(L_DPWM), .s_o(ls), .rise_o(l_rise), .fall_o(l_fall)
   );

   // phase tracking: one shared counter, phase lengths parked until the period closes on the next H rise
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      h_d     = h_q;
      dthl_d  = dthl_q;
      l_d     = l_q;
      hon_d   = hon_q;
      dthlm_d = dthlm_q;
      lon_d   = lon_q;
      dtlh_d  = dtlh_q;
      mv_d    = 1'b0;
      ovl_d   = 1'b0;
      seq_d   = 1'b0;
      count   = 1'b0;
      if (!en) begin
         state_d = IDLE;
      end else if (state_q != IDLE && hs && ls) begin
         state_d = ALIGN;
         ovl_d   = ~both_q;
      end else begin
         case (state_q)
            IDLE: state_d = ALIGN;
            ALIGN: if (h_rise) begin
               state_d = H_ON;
               cnt_d   = ONE;
            end
            H_ON: if (h_fall) begin
               h_d     = cnt_q;
               dthl_d  = '0;
               cnt_d   = ONE;
               state_d = ls ? L_ON : DT_HL;
            end else count = 1'b1;
            DT_HL: if (h_rise) begin
               seq_d   = 1'b1;
               cnt_d   = ONE;
               state_d = H_ON;
            end else if (l_rise) begin
               dthl_d  = cnt_q;
               cnt_d   = ONE;
               state_d = L_ON;
            end else count = 1'b1;
            L_ON: if (l_fall) begin
               l_d     = cnt_q;
               cnt_d   = ONE;
               state_d = hs ? H_ON : DT_LH;
               if (hs) begin
                  mv_d    = 1'b1;
                  hon_d   = h_q;
                  dthlm_d = dthl_q;
                  lon_d   = cnt_q;
                  dtlh_d  = '0;
               end
            end else count = 1'b1;
            DT_LH: if (h_rise) begin
               mv_d    = 1'b1;
               hon_d   = h_q;
               dthlm_d = dthl_q;
               lon_d   = l_q;
               dtlh_d  = cnt_q;
               cnt_d   = ONE;
               state_d = H_ON;
            end else if (l_rise) begin
               seq_d   = 1'b1;
               state_d = ALIGN;
            end else count = 1'b1;
            default: state_d = IDLE;
         endcase
         if (count) begin
            if (cnt_q == CNT_LAST) begin
               seq_d   = 1'b1;
               state_d = ALIGN;
            end else cnt_d = cnt_q + ONE;
         end
      end
   end

   // state, counters, measured outputs and one-cycle pulses
   always_ff @(posedge clk_base) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         h_q     <= '0;
         dthl_q  <= '0;
         l_q     <= '0;
         hon_q   <= '0;
         dthlm_q <= '0;
         lon_q   <= '0;
         dtlh_q  <= '0;
         mv_q    <= 1'b0;
         ovl_q   <= 1'b0;
         seq_q   <= 1'b0;
         both_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         h_q     <= h_d;
         dthl_q  <= dthl_d;
         l_q     <= l_d;
         hon_q   <= hon_d;
         dthlm_q <= dthlm_d;
         lon_q   <= lon_d;
         dtlh_q  <= dtlh_d;
         mv_q    <= mv_d;
         ovl_q   <= ovl_d;
         seq_q   <= seq_d;
         both_q  <= hs & ls;
      end
   end

   assign H_on_meas   = hon_q;
   assign DT_HL_meas  = dthlm_q;
   assign L_on_meas   = lon_q;
   assign DT_LH_meas  = dtlh_q;
   assign meas_valid  = mv_q;
   assign overlap_err = ovl_q;
   assign seq_err     = seq_q;
endmodule

// File: tb/tb_dpwm_capture.sv
// tb_dpwm_capture: period-level reference model with directed, table and random waveforms
module tb_dpwm_capture;
   typedef struct {int h; int dthl; int l; int dtlh;} meas_t;
   typedef struct {int h; int d1; int l; int d2; meas_t e;} vec_t;

   logic clk = 1'b0, rst = 1'b1, en = 1'b0, H = 1'b0, L = 1'b0;
   logic [12:0] hon, dthl, lon, dtlh;
   logic [5:0] hon6, dthl6, lon6, dtlh6;
   logic mv, ovl, seq, mv6, ovl6, seq6;
   int checks = 0, errors = 0;
   int n_mv = 0, n_ovl = 0, n_seq = 0, n_mv6 = 0, n_ovl6 = 0, n_seq6 = 0;
   meas_t exp_q[$];
   meas_t last;
   bit have_last = 0;
   vec_t tbl[6];

   always #5 clk = ~clk;

   dpwm_capture #(.Dc_length(13), .SYNC_STAGES(2)) dut (
      .clk_base(clk), .rst(rst), .en(en), .H_DPWM(H), .L_DPWM(L),
      .H_on_meas(hon), .DT_HL_meas(dthl), .L_on_meas(lon), .DT_LH_meas(dtlh),
      .meas_valid(mv), .overlap_err(ovl), .seq_err(seq)
   );
   dpwm_capture #(.Dc_length(6), .SYNC_STAGES(3)) dut6 (
      .clk_base(clk), .rst(rst), .en(en), .H_DPWM(H), .L_DPWM(L),
      .H_on_meas(hon6), .DT_HL_meas(dthl6), .L_on_meas(lon6), .DT_LH_meas(dtlh6),
      .meas_valid(mv6), .overlap_err(ovl6), .seq_err(seq6)
   );

   task automatic check_eq(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // every valid pulse must match the oldest completed period the model expects
   always @(negedge clk) begin
      meas_t e;
      if (mv) begin
         if (exp_q.size() == 0) check_eq("unexpected_valid", 1, 0);
         else begin
            e = exp_q.pop_front();
            check_eq("H_on_meas", int'(hon), e.h);
            check_eq("DT_HL_meas", int'(dthl), e.dthl);
            check_eq("L_on_meas", int'(lon), e.l);
            check_eq("DT_LH_meas", int'(dtlh), e.dtlh);
         end
      end
      n_mv += int'(mv); n_ovl += int'(ovl); n_seq += int'(seq);
      n_mv6 += int'(mv6); n_ovl6 += int'(ovl6); n_seq6 += int'(seq6);
   end

   task automatic drive(input logic h, input logic l, input int n);
      repeat (n) begin
         @(posedge clk); #2;
         H = h; L = l;
      end
   endtask

   task automatic rise_closes();
      if (have_last) exp_q.push_back(last);
      have_last = 0;
   endtask

   task automatic period(input int h, input int d1, input int l, input int d2, input meas_t e);
      rise_closes();
      drive(1, 0, h); drive(0, 0, d1); drive(0, 1, l); drive(0, 0, d2);
      last = e; have_last = 1;
   endtask

   task automatic start_sec();
      @(posedge clk); #2;
      rst = 1; en = 1; H = 0; L = 0;
      drive(0, 0, 2);
      rst = 0;
      exp_q.delete(); have_last = 0;
      drive(0, 0, 4);
   endtask

   task automatic close_sec(input string name);
      rise_closes();
      drive(1, 0, 2); drive(0, 0, 8);
      check_eq({name, "_pending"}, exp_q.size(), 0);
   endtask

   initial begin
      int mv0, ovl0, seq0, seq60, mv60, ovl60;
      int lat[5];
      int h, d1, l, d2;
      tbl[0] = '{50, 0, 50, 5, '{50, 0, 50, 5}};
      tbl[1] = '{100, 7, 80, 9, '{100, 7, 80, 9}};
      tbl[2] = '{1, 0, 1, 0, '{1, 0, 1, 0}};
      tbl[3] = '{5, 3, 4, 0, '{5, 3, 4, 0}};
      tbl[4] = '{2, 1, 1, 2, '{2, 1, 1, 2}};
      tbl[5] = '{20, 0, 30, 0, '{20, 0, 30, 0}};
      lat = '{0, 0, 0, 1, 0};

      drive(0, 0, 3);
      @(negedge clk);
      check_eq("rst_H_on", int'(hon), 0);
      check_eq("rst_DT_HL", int'(dthl), 0);
      check_eq("rst_L_on", int'(lon), 0);
      check_eq("rst_DT_LH", int'(dtlh), 0);
      check_eq("rst_pulses", int'({mv, ovl, seq}), 0);
      check_eq("rst_dut6", int'({hon6, dthl6, lon6, dtlh6, mv6}), 0);

      // three identical periods, then a closing rise with an exact latency check
      start_sec();
      mv0 = n_mv; ovl0 = n_ovl; seq0 = n_seq;
      repeat (3) period(100, 7, 80, 9, '{100, 7, 80, 9});
      rise_closes();
      @(posedge clk); #2; H = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq($sformatf("latency_%0d", i), int'(mv), lat[i]);
      end
      drive(0, 0, 5);
      check_eq("basic_valids", n_mv - mv0, 3);
      check_eq("basic_errs", (n_ovl - ovl0) + (n_seq - seq0), 0);

      // table of directed periods including zero dead times
      start_sec();
      mv0 = n_mv;
      for (int i = 0; i < 6; i++) period(tbl[i].h, tbl[i].d1, tbl[i].l, tbl[i].d2, tbl[i].e);
      close_sec("table");
      check_eq("table_valids", n_mv - mv0, 6);

      // shoot-through during H_ON
      start_sec();
      mv0 = n_mv; ovl0 = n_ovl; seq0 = n_seq;
      period(100, 7, 80, 9, '{100, 7, 80, 9});
      rise_closes();
      drive(1, 0, 20); drive(1, 1, 3); drive(1, 0, 20);
      check_eq("ovl_pulses", n_ovl - ovl0, 1);
      check_eq("ovl_hold_H", int'(hon), 100);
      check_eq("ovl_hold_L", int'(lon), 80);
      drive(0, 0, 10);
      repeat (2) period(60, 4, 60, 4, '{60, 4, 60, 4});
      close_sec("overlap");
      check_eq("ovl_valids", n_mv - mv0, 3);
      check_eq("ovl_seq", n_seq - seq0, 0);

      // saturation on the 6-bit instance
      start_sec();
      mv60 = n_mv6; seq60 = n_seq6; ovl60 = n_ovl6; seq0 = n_seq;
      drive(1, 0, 70); drive(0, 0, 10);
      check_eq("sat_seq6", n_seq6 - seq60, 1);
      check_eq("sat_valid6", n_mv6 - mv60, 0);
      check_eq("sat_ovl6", n_ovl6 - ovl60, 0);
      check_eq("sat_hold6", int'(hon6), 0);
      check_eq("sat_seq13", n_seq - seq0, 0);

      // H re-rises during DT_HL
      start_sec();
      mv0 = n_mv; seq0 = n_seq;
      drive(1, 0, 10); drive(0, 0, 3);
      repeat (2) period(20, 2, 20, 2, '{20, 2, 20, 2});
      close_sec("dthl_seq");
      check_eq("dthl_seq_pulses", n_seq - seq0, 1);
      check_eq("dthl_seq_valids", n_mv - mv0, 2);

      // reset in L_ON
      start_sec();
      mv0 = n_mv;
      repeat (2) period(30, 3, 30, 3, '{30, 3, 30, 3});
      rise_closes();
      drive(1, 0, 30); drive(0, 0, 3); drive(0, 1, 10);
      @(posedge clk); #2; rst = 1;
      @(posedge clk); #2; rst = 0;
      @(negedge clk);
      check_eq("rstmid_meas", int'(hon) + int'(dthl) + int'(lon) + int'(dtlh), 0);
      check_eq("rstmid_pulses", int'({mv, ovl, seq}), 0);
      have_last = 0;
      drive(0, 1, 10); drive(0, 0, 5);
      repeat (2) period(25, 2, 25, 2, '{25, 2, 25, 2});
      close_sec("rstmid");
      check_eq("rstmid_valids", n_mv - mv0, 4);

      // enable dropped mid-period
      start_sec();
      mv0 = n_mv; ovl0 = n_ovl; seq0 = n_seq;
      period(40, 5, 40, 5, '{40, 5, 40, 5});
      rise_closes();
      drive(1, 0, 20);
      @(posedge clk); #2; en = 0;
      drive(1, 0, 5); drive(0, 0, 5);
      check_eq("en_hold_H", int'(hon), 40);
      check_eq("en_hold_DT", int'(dtlh), 5);
      @(posedge clk); #2; en = 1;
      drive(0, 0, 4);
      repeat (2) period(30, 3, 30, 3, '{30, 3, 30, 3});
      close_sec("en_drop");
      check_eq("en_valids", n_mv - mv0, 3);
      check_eq("en_errs", (n_ovl - ovl0) + (n_seq - seq0), 0);

      // random legal periods
      start_sec();
      mv0 = n_mv; ovl0 = n_ovl; seq0 = n_seq;
      for (int i = 0; i < 30; i++) begin
         h = int'($urandom_range(40, 1)); d1 = int'($urandom_range(10, 0));
         l = int'($urandom_range(40, 1)); d2 = int'($urandom_range(10, 0));
         period(h, d1, l, d2, '{h, d1, l, d2});
      end
      close_sec("random");
      check_eq("random_valids", n_mv - mv0, 30);
      check_eq("random_errs", (n_ovl - ovl0) + (n_seq - seq0), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
